// File: rtl/serial_add_scheduler_if.sv
// Request/grant and result bus shared by the two requesters and the
// bit-serial adder scheduler.
interface serial_add_scheduler_if #(
  parameter int N = 16
);
  logic         req0;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic         cin0;
  logic         req1;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic         cin1;
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output req0, a0, b0, cin0, req1, a1, b1, cin1,
    input  gnt0, gnt1, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req0, a0, b0, cin0, req1, a1, b1, cin1,
    output gnt0, gnt1, busy, done, done_id, sum, cout
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// Two-port round-robin scheduler around an N-bit bit-serial adder.
// One operation: capture edge, N add edges (LSB first), then a one-cycle
// DONE state before requests are sampled again.
module serial_add_scheduler #(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_add_scheduler_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_c;
  logic [N-1:0] r_res;
  logic [CW-1:0] r_cnt;
  logic         r_last;
  logic         r_owner;

  logic         r_gnt0;
  logic         r_gnt1;
  logic         r_done;
  logic         r_done_id;
  logic [N-1:0] r_sum;
  logic         r_cout;

  logic         w_any;
  logic         w_win;
  logic         w_last_add;
  logic         w_s;
  logic         w_cy;
  logic [N-1:0] w_res;

  // A lone requester wins; on a tie the one that did not win last time wins.
  assign w_any      = bus.req0 | bus.req1;
  assign w_win      = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_last_add = (r_cnt == CW'(N - 1));

  // One-bit full adder on the operand LSBs and the carry flop.
  assign w_s   = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cy  = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_res = {w_s, r_res[N-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ADD;
      S_ADD:   if (w_last_add) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture, serial add datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= 1'b0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= w_win ? bus.a1   : bus.a0;
            r_b     <= w_win ? bus.b1   : bus.b0;
            r_c     <= w_win ? bus.cin1 : bus.cin0;
            r_cnt   <= '0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_owner <= w_win;
            r_last  <= w_win;
          end
        end
        S_ADD: begin
          r_c   <= w_cy;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res;
          r_cnt <= r_cnt + CW'(1);
          // Last add edge: publish the full result including this bit.
          if (w_last_add) begin
            r_sum     <= w_res;
            r_cout    <= w_cy;
            r_done_id <= r_owner;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.sum     = r_sum;
  assign bus.cout    = r_cout;
endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler: single ops on both ports,
// carry cases, ignored requests, mid-op reset and alternating arbitration.
module tb_serial_add_scheduler;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_add_scheduler_if #(.N(N)) bus ();

  serial_add_scheduler #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check grant, latency, hold of prior result, and result.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] es, input logic ec);
    logic [15:0] ps;
    logic        pc, pid;
    bit          got, held;
    int          lat;
    ps = bus.sum; pc = bus.cout; pid = bus.done_id;
    if (id == 1'b0) begin
      bus.a0 = a; bus.b0 = b; bus.cin0 = cin; bus.req0 = 1'b1;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.cin1 = cin; bus.req1 = 1'b1;
    end
    got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ((id ? bus.gnt1 : bus.gnt0) === 1'b1) begin got = 1; break; end
    end
    chk("gnt", got, 1);
    chk("gnt_other", id ? bus.gnt0 : bus.gnt1, 0);
    chk("busy_add", bus.busy, 1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    got = 0; held = 1; lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (bus.done === 1'b1) begin got = 1; break; end
      if (bus.sum !== ps || bus.cout !== pc || bus.done_id !== pid) held = 0;
    end
    chk("done_seen", got, 1);
    chk("latency", lat, 16);
    chk("hold", held, 1);
    chk("sum", bus.sum, es);
    chk("cout", bus.cout, ec);
    chk("done_id", bus.done_id, id);
  endtask

  initial begin
    bit   bad, held, got;
    int   cyc, last_cyc, ngr, ndone;
    logic pend;

    rst = 1'b0;
    bus.req0 = 0; bus.a0 = 0; bus.b0 = 0; bus.cin0 = 0;
    bus.req1 = 0; bus.a1 = 0; bus.b1 = 0; bus.cin1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", bus.sum, 0);
    chk("rst_flags", {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.cout}, 0);
    @(negedge clk) rst = 1'b1;
    tick();

    do_op(1'b0, 16'd101, 16'd108, 1'b0, 16'd209, 1'b0);
    do_op(1'b0, 16'd101, 16'd108, 1'b1, 16'd210, 1'b0);
    do_op(1'b1, 16'd999, 16'd1, 1'b1, 16'd1001, 1'b0);
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'd0, 1'b1);
    do_op(1'b1, 16'd255, 16'd255, 1'b0, 16'd510, 1'b0);

    // req1 pulsed during ADD and DONE must be ignored and not queued.
    bus.a0 = 16'd3; bus.b0 = 16'd4; bus.cin0 = 1'b0; bus.req0 = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.gnt0 === 1'b1) begin got = 1; break; end
    end
    chk("ign_gnt0", got, 1);
    bus.req0 = 1'b0;
    bad = 0; held = 1;
    for (int i = 1; i <= 16; i++) begin
      bus.req1 = (i >= 3 && i <= 8);
      tick();
      if (bus.gnt1 === 1'b1) bad = 1;
      if (i < 16 && (bus.sum !== 16'd510 || bus.done_id !== 1'b1)) held = 0;
    end
    bus.req1 = 1'b0;
    chk("ign_add_gnt1", bad, 0);
    chk("ign_hold", held, 1);
    chk("ign_done", bus.done, 1);
    chk("ign_sum", bus.sum, 7);
    bus.req1 = 1'b1;
    tick();
    bus.req1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.gnt1 === 1'b1 || bus.busy === 1'b1 || bus.done === 1'b1) bad = 1;
    end
    chk("ign_done_q", bad, 0);
    chk("ign_sum_keep", {bus.cout, bus.done_id, bus.sum}, {1'b0, 1'b0, 16'd7});

    // Asynchronous reset right after add edge 7 aborts the operation.
    bus.a0 = 16'd1000; bus.b0 = 16'd2000; bus.cin0 = 1'b0; bus.req0 = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.gnt0 === 1'b1) begin got = 1; break; end
    end
    chk("rmid_gnt0", got, 1);
    bus.req0 = 1'b0;
    repeat (7) tick();
    chk("rmid_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("rmid_sum", bus.sum, 0);
    chk("rmid_flags", {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.cout}, 0);
    @(negedge clk) rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) bad = 1;
    end
    chk("rmid_no_done", bad, 0);

    // Both requesters held: grants alternate 0,1,0,1 starting from 0.
    bus.a0 = 16'd1000;  bus.b0 = 16'd2000;  bus.cin0 = 1'b0;
    bus.a1 = 16'h8000;  bus.b1 = 16'h8000;  bus.cin1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    cyc = 0; last_cyc = 0; ngr = 0; ndone = 0; pend = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      cyc++;
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
        chk("arb_excl", bus.gnt0 & bus.gnt1, 0);
        chk("arb_gnt", bus.gnt1, ngr % 2);
        if (ngr > 0) chk("arb_gap", cyc - last_cyc, 18);
        last_cyc = cyc;
        pend = bus.gnt1;
        ngr++;
      end
      if (bus.done === 1'b1) begin
        chk("arb_id", bus.done_id, pend);
        chk("arb_sum", {bus.cout, bus.sum}, pend ? {1'b1, 16'd1} : {1'b0, 16'd3000});
        ndone++;
        if (ndone == 4) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
          break;
        end
      end
    end
    chk("arb_done", ndone, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
